// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encoding and
// default timing constants.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int unsigned DEF_REFRESH_DIV  = 50000;
  localparam int unsigned DEF_BLANK_CYCLES = 2;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to seven-segment glyph, {g,f,e,d,c,b,a}, active-low segments
// for common-anode displays.
module seven_seg_decoder (
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  // Patterns written as lit-segment masks, inverted for active-low drive.
  always_comb begin
    seg = ~7'h00;
    case (bin)
      4'h0: seg = ~7'h3F;
      4'h1: seg = ~7'h06;
      4'h2: seg = ~7'h5B;
      4'h3: seg = ~7'h4F;
      4'h4: seg = ~7'h66;
      4'h5: seg = ~7'h6D;
      4'h6: seg = ~7'h7D;
      4'h7: seg = ~7'h07;
      4'h8: seg = ~7'h7F;
      4'h9: seg = ~7'h6F;
      4'hA: seg = ~7'h77;
      4'hB: seg = ~7'h7C;
      4'hC: seg = ~7'h39;
      4'hD: seg = ~7'h5E;
      4'hE: seg = ~7'h79;
      4'hF: seg = ~7'h71;
      default: seg = ~7'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller: double-buffered display word, per-slot
// blank interval, optional leading-zero suppression, one shared decoder.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int unsigned VW = 4 * N_DIGITS;
  localparam int unsigned IW = $clog2(N_DIGITS);
  localparam int unsigned CW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  scan_state_t          state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [IW-1:0]        idx, idx_nx;
  logic [VW-1:0]        disp_v, disp_v_nx, pend_v, pend_v_nx;
  logic [N_DIGITS-1:0]  disp_dp, disp_dp_nx, pend_dp, pend_dp_nx;
  logic                 pend_f, pend_f_nx;
  logic [3:0]           nib, nib_nx;
  logic [N_DIGITS-1:0]  an_nx;
  logic                 dp_nx, fd_nx;
  logic                 frame_end, supp, lit;

  function automatic logic [3:0] sel_nib(input logic [VW-1:0] w, input logic [IW-1:0] i);
    logic [3:0] r;
    r = 4'h0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (i == IW'(k)) r = w[4*k +: 4];
    end
    return r;
  endfunction

  // Digit i>0 is blanked when it and every more significant nibble are zero.
  function automatic logic lz_supp(input logic [VW-1:0] w, input logic [IW-1:0] i,
                                   input logic lz);
    logic upper_nz;
    upper_nz = 1'b0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (k >= int'(i) && w[4*k +: 4] != 4'h0) upper_nz = 1'b1;
    end
    return lz && (i != '0) && !upper_nz;
  endfunction

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    disp_v_nx  = disp_v;
    disp_dp_nx = disp_dp;
    pend_v_nx  = pend_v;
    pend_dp_nx = pend_dp;
    pend_f_nx  = pend_f;
    frame_end  = 1'b0;
    supp       = 1'b0;
    lit        = 1'b0;
    an_nx      = '1;
    dp_nx      = 1'b0;
    fd_nx      = 1'b0;
    nib_nx     = 4'h0;

    case (state)
      IDLE: begin
        idx_nx = '0;
        cnt_nx = '0;
        if (en) state_nx = BLANK;
      end
      BLANK: begin
        if (!en) begin
          state_nx = IDLE;
          idx_nx   = '0;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
          if (cnt == BLANK_LAST) state_nx = SHOW;
        end
      end
      SHOW: begin
        if (!en) begin
          state_nx = IDLE;
          idx_nx   = '0;
          cnt_nx   = '0;
        end else if (cnt == SLOT_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
        cnt_nx   = '0;
      end
    endcase

    // The shown word only changes at a frame boundary or when leaving the scan.
    frame_end = (state != IDLE) &&
                (!en || (state == SHOW && cnt == SLOT_LAST && idx == IDX_LAST));

    if (state == IDLE) begin
      if (load) begin
        disp_v_nx  = value;
        disp_dp_nx = dp_in;
      end
    end else if (frame_end) begin
      if (load) begin
        disp_v_nx  = value;
        disp_dp_nx = dp_in;
      end else if (pend_f) begin
        disp_v_nx  = pend_v;
        disp_dp_nx = pend_dp;
      end
      pend_f_nx = 1'b0;
    end else if (load) begin
      pend_v_nx  = value;
      pend_dp_nx = dp_in;
      pend_f_nx  = 1'b1;
    end

    // Outputs are registered, so they are derived from the next-cycle view.
    nib_nx = sel_nib(disp_v_nx, idx_nx);
    supp   = lz_supp(disp_v_nx, idx_nx, lz_en);
    lit    = (state_nx == SHOW) && !supp;
    if (lit) an_nx[idx_nx] = 1'b0;
    dp_nx  = lit && disp_dp_nx[idx_nx];
    fd_nx  = (state_nx == SHOW) && (idx_nx == IDX_LAST) && (cnt_nx == SLOT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      disp_v     <= '0;
      disp_dp    <= '0;
      pend_v     <= '0;
      pend_dp    <= '0;
      pend_f     <= 1'b0;
      nib        <= 4'h0;
      an         <= '1;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      disp_v     <= disp_v_nx;
      disp_dp    <= disp_dp_nx;
      pend_v     <= pend_v_nx;
      pend_dp    <= pend_dp_nx;
      pend_f     <= pend_f_nx;
      nib        <= nib_nx;
      an         <= an_nx;
      dp         <= dp_nx;
      frame_done <= fd_nx;
    end
  end

  seven_seg_decoder u_dec (
    .bin (nib),
    .seg (seg)
  );

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a frame-position reference model.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        rst, en, load, lz_en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Lit-segment masks {g..a}; the display drives them active-low.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference: scanning flag, position inside the frame, shown/pending words.
  bit          m_act = 0;
  int          m_t   = 0;
  logic [15:0] m_dv = '0, m_pv = '0;
  logic [3:0]  m_dd = '0, m_pd = '0;
  bit          m_pf = 0;
  bit          m_lz = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_act = 0; m_t = 0; m_dv = '0; m_dd = '0; m_pv = '0; m_pd = '0; m_pf = 0;
    end else if (!m_act) begin
      if (load) begin m_dv = value; m_dd = dp_in; end
      if (en) begin m_act = 1; m_t = 0; end
    end else if (!en || m_t == FRAME - 1) begin
      if (load) begin m_dv = value; m_dd = dp_in; end
      else if (m_pf) begin m_dv = m_pv; m_dd = m_pd; end
      m_pf = 0;
      m_t  = 0;
      if (!en) m_act = 0;
    end else begin
      if (load) begin m_pv = value; m_pd = dp_in; m_pf = 1; end
      m_t++;
    end
    m_lz = lz_en;
  endtask

  task automatic check_outputs();
    int          d, w;
    logic        show, supp;
    logic [15:0] hi;
    logic [3:0]  an_e, nib_e;
    logic        dp_e, fd_e;
    logic [6:0]  seg_e;
    if (m_act) begin
      d     = m_t / RD;
      w     = m_t % RD;
      show  = (w >= BC);
      hi    = m_dv >> (4 * d);
      supp  = m_lz && (d > 0) && (hi == 16'h0);
      nib_e = hi[3:0];
      if (show && !supp) begin
        an_e = ~(4'b0001 << d);
        dp_e = m_dd[d];
      end else begin
        an_e = 4'hF;
        dp_e = 1'b0;
      end
      fd_e = (m_t == FRAME - 1);
    end else begin
      an_e  = 4'hF;
      dp_e  = 1'b0;
      fd_e  = 1'b0;
      nib_e = m_dv[3:0];
    end
    seg_e = ~glyph[nib_e];
    check("an", an, an_e);
    check("dp", dp, dp_e);
    check("frame_done", frame_done, fd_e);
    check("seg", seg, seg_e);
    check("an_onehot", $countones(~an) <= 1, 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Advance until the model sits at frame position 'target'; bounded.
  task automatic wait_t(input int target);
    for (int i = 0; i < 4 * FRAME && !(m_act && m_t == target); i++) step();
    check("wait_pos", (m_act && m_t == target), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; lz_en = 1'b0; value = '0; dp_in = '0;

    // Reset held with en=1, then release into the first slot.
    run(3);
    rst = 1'b0;
    run(12);

    // Scan order with a decimal point on digit 2.
    rst = 1'b1; en = 1'b0; run(1);
    rst = 1'b0;
    do_load(16'h1234, 4'b0100);
    en = 1'b1;
    run(70);

    // Leading-zero suppression.
    lz_en = 1'b1;
    do_load(16'h0070, 4'b0000);
    run(70);
    do_load(16'h0000, 4'b1111);
    run(70);

    // Tearing: a load during digit 1 waits for the frame boundary.
    lz_en = 1'b0;
    do_load(16'h1234, 4'b0000);
    wait_t(0);
    wait_t(9);
    do_load(16'hABCD, 4'b0001);
    run(60);
    // Load coincident with frame_done goes straight to the display.
    wait_t(FRAME - 1);
    do_load(16'h5E6F, 4'b1000);
    run(40);

    // Enable dropped in digit 2's SHOW, then restored.
    wait_t(2 * RD + 4);
    en = 1'b0;
    run(6);
    en = 1'b1;
    run(40);

    // Reset during digit 1's SHOW with a load pending.
    wait_t(RD + 3);
    do_load(16'h9876, 4'b1111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(40);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 119) == 0) en = ~en;
      if ($urandom_range(0, 249) == 0) lz_en = ~lz_en;
      load  = ($urandom_range(0, 19) == 0);
      value = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in = 4'($urandom);
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one seven_seg_decoder instance across N_DIGITS common-anode digits. It holds a double-buffered display word and cycles through the digits with a fixed dwell time and an anti-ghosting blank interval. It optionally suppresses leading zeros. It sits between the value-producing logic, such as counters and the ALU result path, and the board's segment/anode pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot, blank interval included (>= 2)
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (1 .. REFRESH_DIV-1)

Ports:
clk  in  1  system clock
rst  in  1  reset
en  in  1  scan enable; 0 = display dark
load  in  1  one-cycle strobe; capture value and dp_in
value  in  4*N_DIGITS  nibble i = digit i (digit 0 = rightmost/LSB)
dp_in  in  N_DIGITS  decimal point per digit, active-high
lz_en  in  1  leading-zero suppression enable
seg  out  7  {g,f,e,d,c,b,a}, driven straight from the shared decoder
dp  out  1  decimal point of the digit currently shown, active-high
an  out  N_DIGITS  anode enables, active-low, one-hot-low or all-ones
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - an = all ones; dp = 0; frame_done = 0.
  - Display register, pending register, pending flag, digit index and slot counter = 0.
  - State = IDLE; decoder input = 4'h0.
- State IDLE (en=0):
  - an all ones, dp = 0, digit index held at 0.
  - A load writes the display register directly on the next edge.
- Start of scan: IDLE with en=1 goes to BLANK for digit 0 on the next edge.
- State BLANK:
  - an all ones; decoder input already holds the nibble for the current digit.
  - Lasts BLANK_CYCLES cycles, then goes to SHOW.
- State SHOW:
  - an[idx] = 0 unless the digit is suppressed; dp = dp bit of idx.
  - Lasts REFRESH_DIV - BLANK_CYCLES cycles.
  - Then idx increments and the state returns to BLANK.
  - Wrap-around: on idx = N_DIGITS-1, idx goes to 0 and frame_done pulses for the one cycle that is the last SHOW cycle.
- Timing: slot = REFRESH_DIV cycles; frame = N_DIGITS*REFRESH_DIV cycles. The decoder is combinational, so seg follows the registered nibble with no added latency.
- Double buffering while scanning:
  - load writes the pending register and sets the pending flag.
  - Repeated loads within one frame: the last one wins.
  - At the frame wrap, display <= pending and the flag clears.
  - A load in the same cycle as the wrap bypasses pending and goes into the display register directly.
  - The displayed frame never mixes old and new words.
- Leading-zero suppression: with lz_en=1, digit i (i>0) is suppressed when nibbles N_DIGITS-1 down to i are all 0.
  - A suppressed digit keeps an[i]=1 and dp=0 for its whole slot; slot timing is unchanged.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- en dropped mid-frame:
  - Next edge: IDLE, an all ones, idx = 0, no frame_done.
  - A pending word moves to the display register on entering IDLE.
- rst mid-operation: everything returns to reset values on that edge, whatever the state or pending status.
- Invariant: at most one an bit is low in any cycle.

Decomposition:
- Shared package/header (seven_seg_pkg): state encodings (IDLE=2'd0, BLANK=2'd1, SHOW=2'd2) and the default REFRESH_DIV/BLANK_CYCLES constants.
- One sub-module: the existing seven_seg_decoder, instantiated once (bin from the selected nibble, seg to the output).
- Slot counter, digit index, FSM, buffers and suppression logic stay inline.

Test Plan:
All scenarios use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset:
   - Stimulus: rst=1 for 3 cycles with en=1.
   - Required during reset: an=4'b1111, dp=0, frame_done=0.
   - Required after release: an=4'b1111 for 3 cycles, then an=4'b1110 for 6 cycles.
2. Scan order:
   - Stimulus: load value=16'h1234, dp_in=4'b0100, lz_en=0 while IDLE, then en=1.
   - Required:
     - Nibbles 4,3,2,1 appear with an=1110, 1101, 1011, 0111.
     - dp=1 only during the an=1011 SHOW window.
     - frame_done pulses every 32 cycles.
3. Leading zeros:
   - Stimulus: lz_en=1 with value=16'h0070.
   - Required: an[3] and an[2] stay 1; digits 1 ("7") and 0 ("0") are shown.
   - Stimulus: value=16'h0000.
   - Required: only an[0] ever goes low.
4. Tearing:
   - Stimulus: load 16'hABCD during digit 1 of a 16'h1234 frame.
   - Required: digits 2 and 3 still show 2 and 1; the next frame shows D,C,B,A.
   - Stimulus: a load coincident with frame_done.
   - Required: the new word is displayed from the very next frame.
5. Enable drop:
   - Stimulus: en=0 in the middle of digit 2's SHOW.
   - Required: an=4'b1111 on the next cycle, no frame_done.
   - Stimulus: en=1 again.
   - Required: restart at digit 0 BLANK.
6. Reset mid-SHOW with a load pending:
   - Stimulus: rst during digit 1's SHOW while a load is pending.
   - Required: an=4'b1111 and display register 0; after release with en=1, digit 0 shows "0".
